// File: rtl/regfile_bank.sv
// 32-entry architectural register file with a single write port and a pending-write
// scoreboard (busy vector + sticky orphan-write flag). Register 0 reads as zero.
module regfile_bank #(
    parameter int unsigned           WIDTH       = 32,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  write_enable,
    input  logic [4:0]            write_reg,
    input  logic [WIDTH-1:0]      write_data,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_reg,
    output logic [32*WIDTH-1:0]   regs_flat,
    output logic [31:0]           busy,
    output logic                  orphan_write
);

    logic [WIDTH-1:0] regs_q [1:31];
    logic [WIDTH-1:0] regs_d [1:31];
    logic [31:0]      busy_q, busy_d;
    logic             orphan_q, orphan_d;

    always_comb begin
        for (int unsigned k = 1; k < 32; k++) begin
            regs_d[k] = regs_q[k];
            if (write_enable && (write_reg == 5'(k))) begin
                regs_d[k] = write_data;
            end
        end
    end

    // Issue takes priority over a same-cycle writeback: the newer producer owns the register.
    always_comb begin
        busy_d    = busy_q;
        busy_d[0] = 1'b0;
        for (int unsigned k = 1; k < 32; k++) begin
            if (issue_valid && (issue_reg == 5'(k))) begin
                busy_d[k] = 1'b1;
            end else if (write_enable && (write_reg == 5'(k))) begin
                busy_d[k] = 1'b0;
            end
        end
    end

    always_comb begin
        orphan_d = orphan_q;
        if (write_enable && (write_reg != 5'd0) && !busy_q[write_reg]
            && !(issue_valid && (issue_reg == write_reg))) begin
            orphan_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 1; k < 32; k++) begin
                regs_q[k] <= RESET_VALUE;
            end
            busy_q   <= '0;
            orphan_q <= 1'b0;
        end else begin
            for (int unsigned k = 1; k < 32; k++) begin
                regs_q[k] <= regs_d[k];
            end
            busy_q   <= busy_d;
            orphan_q <= orphan_d;
        end
    end

    always_comb begin
        regs_flat[WIDTH-1:0] = '0;
        for (int unsigned k = 1; k < 32; k++) begin
            regs_flat[k*WIDTH +: WIDTH] = regs_q[k];
        end
    end

    assign busy         = busy_q;
    assign orphan_write = orphan_q;

endmodule

// File: tb/tb_regfile_bank.sv
// Self-checking bench for regfile_bank: directed scenarios followed by random traffic,
// all compared against an array-based reference model of the register file.
module tb_regfile_bank;

    localparam int unsigned W = 32;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            write_enable = 1'b0;
    logic [4:0]      write_reg = '0;
    logic [W-1:0]    write_data = '0;
    logic            issue_valid = 1'b0;
    logic [4:0]      issue_reg = '0;
    logic [32*W-1:0] regs_flat;
    logic [31:0]     busy;
    logic            orphan_write;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [W-1:0] m_reg [32];
    bit           m_busy [32];
    bit           m_orphan;

    regfile_bank #(.WIDTH(W), .RESET_VALUE('0)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .issue_valid  (issue_valid),
        .issue_reg    (issue_reg),
        .regs_flat    (regs_flat),
        .busy         (busy),
        .orphan_write (orphan_write)
    );

    always #5 clock = ~clock;

    // Read port modelled as a 32:1 mux selecting in_k from the flattened bus.
    function automatic logic [W-1:0] rd_mux(input logic [32*W-1:0] flat, input logic [4:0] sel);
        return flat[int'(sel)*W +: W];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic check_all(input string where);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s reg%0d", where, i), rd_mux(regs_flat, 5'(i)), m_reg[i]);
        end
        chk({where, " busy"}, busy, model_busy_vec());
        chk({where, " orphan"}, {31'b0, orphan_write}, {31'b0, m_orphan});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_orphan = 1'b0;
    endtask

    // One clock: drive at negedge, advance the model, sample 1 time unit after posedge.
    task automatic step(input bit iv, input logic [4:0] ir, input bit we,
                        input logic [4:0] wr, input logic [W-1:0] wd, input string where);
        bit same;
        @(negedge clock);
        issue_valid  = iv;
        issue_reg    = ir;
        write_enable = we;
        write_reg    = wr;
        write_data   = wd;
        same = iv && (ir == wr);
        if (we && wr != 0) begin
            if (!m_busy[wr] && !same) m_orphan = 1'b1;
            m_reg[wr] = wd;
            if (!same) m_busy[wr] = 1'b0;
        end
        if (iv && ir != 0) m_busy[ir] = 1'b1;
        @(posedge clock);
        #1;
        check_all(where);
    endtask

    task automatic idle(input string where);
        step(1'b0, 5'd0, 1'b0, 5'd0, '0, where);
    endtask

    initial begin
        // Reset held for two cycles, released away from the clock edge.
        model_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_all("reset");

        // Basic issue then writeback.
        step(1'b1, 5'd5, 1'b0, 5'd0, '0, "issue5");
        chk("busy_after_issue5", busy, 32'h0000_0020);
        idle("idle_a");
        step(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, "write5");
        chk("reg5_slice", regs_flat[191:160], 32'hDEAD_BEEF);
        chk("busy_after_write5", busy, 32'h0);

        // Register 0 immunity.
        step(1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, "reg0");
        chk("reg0_slice", regs_flat[31:0], 32'h0);
        chk("busy0", {31'b0, busy[0]}, 32'h0);
        chk("orphan_after_reg0", {31'b0, orphan_write}, 32'h0);

        // Same-cycle issue and writeback to one register.
        step(1'b1, 5'd7, 1'b0, 5'd0, '0, "issue7");
        step(1'b1, 5'd7, 1'b1, 5'd7, 32'h0000_1234, "issue_write7");
        chk("reg7_same_cycle", regs_flat[7*W +: W], 32'h0000_1234);
        chk("busy7_same_cycle", {31'b0, busy[7]}, 32'h1);
        step(1'b0, 5'd0, 1'b1, 5'd7, 32'h0000_5678, "write7");
        chk("busy7_cleared", {31'b0, busy[7]}, 32'h0);
        chk("orphan_not_set", {31'b0, orphan_write}, 32'h0);

        // Orphan write: performed and flagged, flag sticks.
        step(1'b0, 5'd0, 1'b1, 5'd9, 32'hA5A5_A5A5, "orphan9");
        chk("reg9", regs_flat[9*W +: W], 32'hA5A5_A5A5);
        chk("orphan_set", {31'b0, orphan_write}, 32'h1);
        for (int i = 0; i < 10; i++) idle("orphan_hold");
        chk("orphan_sticky", {31'b0, orphan_write}, 32'h1);

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        step(1'b1, 5'd12, 1'b1, 5'd3, 32'h0BAD_F00D, "prereset");
        @(negedge clock);
        write_enable = 1'b0;
        issue_valid  = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_all("post_release");

        // Sweep: issue i while writing back i-1.
        step(1'b1, 5'd1, 1'b0, 5'd0, '0, "sweep_issue1");
        for (int i = 2; i < 32; i++) begin
            step(1'b1, 5'(i), 1'b1, 5'(i - 1), W'(i - 1) * 32'h0101_0101, "sweep");
        end
        step(1'b0, 5'd0, 1'b1, 5'd31, 32'd31 * 32'h0101_0101, "sweep_last");
        chk("sweep_busy_zero", busy, 32'h0);
        chk("sweep_no_orphan", {31'b0, orphan_write}, 32'h0);
        chk("sweep_reg31", regs_flat[31*W +: W], 32'h1F1F_1F1F);
        chk("sweep_reg1", regs_flat[1*W +: W], 32'h0101_0101);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), W'($urandom), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: observed no completion, expected finish before 200000");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
